// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, scan state type and leading-zero helper for seg_scan_ctrl
package seg_pkg;

    localparam int NDIG = 4;
    localparam logic [3:0] AN_OFF = 4'b1111;

    typedef enum logic {DISP, GAP} state_t;

    // True when nibbles i..3 of v are all zero, i.e. digit i is a leading zero
    function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] i);
        return (v >> {i, 2'b00}) == 16'h0;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: load/value/lz_en in, bcd/an/load_ack out of the scan controller
interface seg_scan_ctrl_if;

    logic        load;
    logic [15:0] value;
    logic        lz_en;
    logic [3:0]  bcd;
    logic [3:0]  an;
    logic        load_ack;

    modport master (output load, value, lz_en, input bcd, an, load_ack);
    modport slave  (input load, value, lz_en, output bcd, an, load_ack);

endinterface

// File: rtl/scan_timer.sv
// scan_timer: slot counter with terminal count for the DISP/GAP phases; ports clk, reset, state in, tc out
module scan_timer
    import seg_pkg::*;
#(
    parameter int DIV = 1000,
    parameter int GAP = 50
) (
    input  logic   clk,
    input  logic   reset,
    input  state_t state,
    output logic   tc
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] DISP_LAST = CW'(DIV - GAP - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tc    = (state == seg_pkg::DISP) ? (cnt_q == DISP_LAST) : (cnt_q == GAP_LAST);
        cnt_d = tc ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit multiplexed display scanner; ports clk, reset, bus (slave: load/value/lz_en in, bcd/an/load_ack out)
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIV = 1000,
    parameter int GAP = 50
) (
    input  logic           clk,
    input  logic           reset,
    seg_scan_ctrl_if.slave bus
);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] active_q, active_d, shadow_q, shadow_d;
    logic        pending_q, pending_d, ack_q, ack_d;
    logic [3:0]  an_q, an_d;
    logic        tc, boundary, commit;

    scan_timer #(.DIV(DIV), .GAP(GAP)) u_timer (
        .clk   (clk),
        .reset (reset),
        .state (state_q),
        .tc    (tc)
    );

    // an is computed from next-state values so the registered anode lines up with the new slot
    always_comb begin
        boundary  = tc && state_q == seg_pkg::GAP && idx_q == 2'd3;
        commit    = boundary && (pending_q || bus.load);
        state_d   = tc ? ((state_q == seg_pkg::DISP) ? seg_pkg::GAP : seg_pkg::DISP) : state_q;
        idx_d     = (tc && state_q == seg_pkg::GAP) ? idx_q + 2'd1 : idx_q;
        shadow_d  = bus.load ? bus.value : shadow_q;
        active_d  = commit ? (bus.load ? bus.value : shadow_q) : active_q;
        pending_d = boundary ? 1'b0 : (bus.load || pending_q);
        ack_d     = commit;
        an_d      = (state_d == seg_pkg::DISP &&
                     !(bus.lz_en && idx_d != 2'd0 && lz_blank(active_d, idx_d)))
                    ? ~(4'b0001 << idx_d) : AN_OFF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= seg_pkg::GAP;
            idx_q     <= 2'd3;
            active_q  <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            an_q      <= AN_OFF;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            an_q      <= an_d;
        end
    end

    assign bus.bcd      = active_q[{idx_q, 2'b00} +: 4];
    assign bus.an       = an_q;
    assign bus.load_ack = ack_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl with DIV=8, GAP=2
module tb_seg_scan_ctrl;

    localparam int DIV   = 8;
    localparam int GAP   = 2;
    localparam int FRAME = 4 * DIV;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   k = 0;
    logic [15:0] m_active = '0;
    logic [15:0] m_shadow = '0;
    logic        m_pend = 1'b0;
    logic [8:0]  exp_q[$];

    seg_scan_ctrl_if bus();

    seg_scan_ctrl #(.DIV(DIV), .GAP(GAP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at k=%0d: got %h expected %h", tag, k, got, exp);
        end
    endtask

    // Reference timing: k counts edges since the last reset edge; DISP of digit 0 starts at k=GAP
    always @(posedge clk) begin : model
        logic       bnd, ack, disp;
        int         d;
        logic [3:0] an_e;
        ack = 1'b0;
        if (reset) begin
            k        = 0;
            m_active = '0;
            m_shadow = '0;
            m_pend   = 1'b0;
        end else begin
            k++;
            bnd = k >= GAP && (k - GAP) % FRAME == 0;
            ack = bnd && (m_pend || bus.load);
            if (ack) m_active = bus.load ? bus.value : m_shadow;
            if (bus.load) m_shadow = bus.value;
            m_pend = bnd ? 1'b0 : (m_pend || bus.load);
        end
        d    = (k < GAP) ? 3 : ((k - GAP) / DIV) % 4;
        disp = k >= GAP && (k - GAP) % DIV < DIV - GAP;
        an_e = (disp && !(bus.lz_en && d != 0 && (m_active >> (4 * d)) == 16'h0))
               ? ~(4'b0001 << d) : 4'hF;
        exp_q.push_back({an_e, m_active[4*d +: 4], ack});
    end

    always @(negedge clk) begin
        logic [8:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("an", 16'(bus.an), 16'(e[8:5]));
            check("bcd", 16'(bus.bcd), 16'(e[4:1]));
            check("load_ack", 16'(bus.load_ack), 16'(e[0]));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v);
        bus.load  = 1'b1;
        bus.value = v;
        @(negedge clk);
        bus.load  = 1'b0;
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (k >= GAP && (k - GAP) % FRAME == p) return;
            @(negedge clk);
        end
        check("wait_pos", 16'(k % FRAME), 16'(p));
    endtask

    initial begin
        bus.load  = 1'b0;
        bus.value = '0;
        bus.lz_en = 1'b0;
        cyc(3);
        reset = 1'b0;
        cyc(40);
        do_load(16'h1234);
        cyc(70);
        do_load(16'hABCF);
        cyc(40);
        bus.lz_en = 1'b1;
        do_load(16'h0050);
        cyc(70);
        do_load(16'h0000);
        cyc(70);
        wait_pos(5);
        do_load(16'h1111);
        cyc(3);
        do_load(16'h2222);
        cyc(70);
        wait_pos(FRAME - 1);
        do_load(16'h0707);
        cyc(40);
        bus.lz_en = 1'b0;
        wait_pos(2);
        do_load(16'h9999);
        wait_pos(2 * DIV + 2);
        reset     = 1'b1;
        bus.load  = 1'b1;
        bus.value = 16'h5555;
        @(negedge clk);
        reset     = 1'b0;
        bus.load  = 1'b0;
        cyc(80);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
